// File: rtl/uart_word_tx_if.sv
// uart_word_tx_if -- word handshake between a producer and uart_word_tx.
//
// Signals:
//   word_valid_i  producer offers a word this cycle
//   word_i        32-bit word payload, meaningful while word_valid_i is high
//   word_ready_o  transmitter has an empty holding slot
//
// Handshake: a word transfers on every rising clock edge where
// word_valid_i && word_ready_o are both high. The producer may raise
// word_valid_i at any time and may not rely on word_ready_o staying high;
// word_ready_o does not depend combinationally on word_valid_i.
//
// Modports: master = word producer, slave = uart_word_tx.
interface uart_word_tx_if;
  logic        word_valid_i;
  logic [31:0] word_i;
  logic        word_ready_o;

  modport master (output word_valid_i, output word_i, input word_ready_o);
  modport slave  (input word_valid_i, input word_i, output word_ready_o);
endinterface

// File: rtl/uart_word_tx.sv
// uart_word_tx -- serialises 32-bit words onto an 8N1 UART line, least
// significant byte first, NUM_BYTES (1..4) bytes per word.
//
// Ports:
//   clk_i           sole clock, rising edge
//   rst_ni          asynchronous active-low reset
//   clks_per_bit_i  clk_i cycles per bit (0 treated as 1), sampled per byte
//   word_bus        slave side of uart_word_tx_if (valid/ready word input)
//   o_Tx_Serial     serial line, idle high
//   o_Tx_Active     high while any start/data/(parity)/stop bit is on the line
//   o_Tx_Done       one-cycle pulse after each byte's stop bit
//   o_Word_Done     one-cycle pulse with o_Tx_Done of a word's last byte
//   dbg_state_o     current FSM state (IDLE=0 START=1 DATA=2 STOP=3 PARITY=4)
//
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit (11-bit frames).
//
// Storage is one shift word (busy whenever the FSM is not IDLE) plus one
// holding word; word_ready_o reflects only the holding word, so a second word
// can be queued while the first is on the line.
module uart_word_tx #(
  parameter int NUM_BYTES = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [15:0]       clks_per_bit_i,
  uart_word_tx_if.slave     word_bus,
  output logic              o_Tx_Serial,
  output logic              o_Tx_Active,
  output logic              o_Tx_Done,
  output logic              o_Word_Done,
  output logic [2:0]        dbg_state_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd4;
`endif

  localparam logic [1:0] LAST_BYTE = 2'(NUM_BYTES - 1);

  logic [2:0]  state;
  logic [31:0] shift_word;   // bytes not yet started, next byte in [7:0]
  logic [31:0] hold_word;
  logic        hold_full;
  logic        ready_en;     // keeps word_ready_o low until the first clock after reset
  logic [7:0]  tx_sr;        // current byte, next data bit in [0]
  logic [2:0]  bit_idx;
  logic [1:0]  byte_idx;
  logic [15:0] div_q;        // divisor latched for the current byte
  logic [15:0] bit_cnt;
  logic        tx_done_q;
  logic        word_done_q;
`ifdef UART_TX_PARITY_EN
  logic        par_q;
`endif

  logic        accept;
  logic        bit_tick;
  logic        byte_end;
  logic        word_end;
  logic        start_new;
  logic        next_byte;
  logic [31:0] new_word;
  logic [31:0] load_word;
  logic [15:0] div_eff;

  assign word_bus.word_ready_o = ready_en && !hold_full;
  assign accept    = word_bus.word_valid_i && word_bus.word_ready_o;

  // div_q is at least 1 whenever the FSM is active, so the compare never wraps.
  assign bit_tick  = (bit_cnt == div_q - 16'd1);
  assign byte_end  = (state == S_STOP) && bit_tick;
  assign word_end  = byte_end && (byte_idx == LAST_BYTE);
  assign next_byte = byte_end && (byte_idx != LAST_BYTE);

  // A new word enters the shift register either straight from the bus while
  // idle, or from the holding word (while idle, or at the last stop bit's end
  // so the next start bit follows with no gap).
  assign start_new = ((state == S_IDLE) && (hold_full || accept)) ||
                     (word_end && hold_full);
  assign new_word  = hold_full ? hold_word : word_bus.word_i;
  assign load_word = start_new ? new_word : shift_word;
  assign div_eff   = (clks_per_bit_i == 16'd0) ? 16'd1 : clks_per_bit_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= S_IDLE;
      shift_word  <= '0;
      hold_word   <= '0;
      hold_full   <= 1'b0;
      ready_en    <= 1'b0;
      tx_sr       <= '0;
      bit_idx     <= '0;
      byte_idx    <= '0;
      div_q       <= '0;
      bit_cnt     <= '0;
      tx_done_q   <= 1'b0;
      word_done_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      ready_en    <= 1'b1;
      tx_done_q   <= byte_end;
      word_done_q <= word_end;

      // Release first, then capture: hold_full is low whenever accept is
      // possible, so the two never fight over the same word.
      if (start_new && hold_full) begin
        hold_full <= 1'b0;
      end
      if (accept && (state != S_IDLE)) begin
        hold_word <= word_bus.word_i;
        hold_full <= 1'b1;
      end

      if (start_new || next_byte) begin
        tx_sr      <= load_word[7:0];
        shift_word <= load_word >> 8;
        byte_idx   <= start_new ? 2'd0 : byte_idx + 2'd1;
        div_q      <= div_eff;
        bit_cnt    <= '0;
        bit_idx    <= '0;
        state      <= S_START;
`ifdef UART_TX_PARITY_EN
        par_q      <= ^load_word[7:0];
`endif
      end else if (state != S_IDLE) begin
        if (bit_tick) begin
          bit_cnt <= '0;
          case (state)
            S_START: state <= S_DATA;
            S_DATA: begin
              tx_sr   <= tx_sr >> 1;
              bit_idx <= bit_idx + 3'd1;
              if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                state <= S_PARITY;
`else
                state <= S_STOP;
`endif
              end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: state <= S_STOP;
`endif
            // Only the last byte with nothing held gets here.
            S_STOP:  state <= S_IDLE;
            default: state <= S_IDLE;
          endcase
        end else begin
          bit_cnt <= bit_cnt + 16'd1;
        end
      end
    end
  end

  always_comb begin
    o_Tx_Serial = 1'b1;
    case (state)
      S_START:  o_Tx_Serial = 1'b0;
      S_DATA:   o_Tx_Serial = tx_sr[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: o_Tx_Serial = par_q;
`endif
      default:  o_Tx_Serial = 1'b1;
    endcase
  end

  assign o_Tx_Active = (state != S_IDLE);
  assign o_Tx_Done   = tx_done_q;
  assign o_Word_Done = word_done_q;
  assign dbg_state_o = state;

endmodule

// File: tb/tb_uart_word_tx.sv
// tb_uart_word_tx -- self-checking bench for uart_word_tx.
// The reference model turns accepted words into the expected per-cycle line
// trace {serial, active, done, word_done} straight from the framing rules,
// and each scenario compares the captured trace cycle by cycle.
module tb_uart_word_tx;

`ifdef UART_TX_PARITY_EN
  localparam int FL = 11;
`else
  localparam int FL = 10;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] div_a = 16'd4;
  logic [15:0] div_b = 16'd1;

  uart_word_tx_if bus_a ();
  uart_word_tx_if bus_b ();

  logic       a_serial, a_active, a_done, a_wdone;
  logic       b_serial, b_active, b_done, b_wdone;
  logic [2:0] a_state, b_state;

  uart_word_tx #(.NUM_BYTES(4)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .clks_per_bit_i(div_a), .word_bus(bus_a),
    .o_Tx_Serial(a_serial), .o_Tx_Active(a_active), .o_Tx_Done(a_done),
    .o_Word_Done(a_wdone), .dbg_state_o(a_state)
  );

  uart_word_tx #(.NUM_BYTES(1)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .clks_per_bit_i(div_b), .word_bus(bus_b),
    .o_Tx_Serial(b_serial), .o_Tx_Active(b_active), .o_Tx_Done(b_done),
    .o_Word_Done(b_wdone), .dbg_state_o(b_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];   // {serial, active, done, word_done} per cycle
  logic [3:0] obs_q[$];
  bit pend_done, pend_wdone;

  task automatic model_clear();
    exp_q.delete();
    obs_q.delete();
    pend_done  = 1'b0;
    pend_wdone = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] b, input int div, input bit last);
    int d;
    logic [10:0] frame;
    d = (div < 1) ? 1 : div;
`ifdef UART_TX_PARITY_EN
    frame = {1'b1, ^b, b, 1'b0};
`else
    frame = {1'b0, 1'b1, b, 1'b0};
`endif
    for (int k = 0; k < FL; k++) begin
      for (int c = 0; c < d; c++) begin
        exp_q.push_back({frame[k], 1'b1, pend_done, pend_wdone});
        pend_done  = 1'b0;
        pend_wdone = 1'b0;
      end
    end
    pend_done  = 1'b1;
    pend_wdone = last;
  endtask

  task automatic model_word(input logic [31:0] w, input int div, input int nb);
    logic [31:0] t;
    for (int i = 0; i < nb; i++) begin
      t = w >> (8 * i);
      model_byte(t[7:0], div, i == nb - 1);
    end
  endtask

  task automatic model_idle(input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({1'b1, 1'b0, pend_done, pend_wdone});
      pend_done  = 1'b0;
      pend_wdone = 1'b0;
    end
  endtask

  // ---------------- driver / monitor tasks ----------------
  // Offers w on the selected bus; returns in the cycle after acceptance (#1 in).
  task automatic send(input bit sel_b, input logic [31:0] w, output int waited);
    logic rdy;
    @(posedge clk); #1;
    if (sel_b) begin bus_b.word_valid_i = 1'b1; bus_b.word_i = w; end
    else       begin bus_a.word_valid_i = 1'b1; bus_a.word_i = w; end
    waited = 0;
    rdy = sel_b ? bus_b.word_ready_o : bus_a.word_ready_o;
    while (!rdy && waited < 2000) begin
      @(posedge clk); #1;
      waited++;
      rdy = sel_b ? bus_b.word_ready_o : bus_a.word_ready_o;
    end
    checks++;
    if (!rdy) begin
      errors++;
      $display("FAIL send_timeout: ready=%b after %0d cycles, required 1", rdy, waited);
    end
    @(posedge clk); #1;
    // Scramble the payload after acceptance; the DUT must have captured it.
    if (sel_b) begin bus_b.word_valid_i = 1'b0; bus_b.word_i = $urandom; end
    else       begin bus_a.word_valid_i = 1'b0; bus_a.word_i = $urandom; end
  endtask

  task automatic capture(input int n, input bit sel_b);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (sel_b) obs_q.push_back({b_serial, b_active, b_done, b_wdone});
      else       obs_q.push_back({a_serial, a_active, a_done, a_wdone});
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (a_serial !== 1'b1) begin errors++; $display("FAIL reset_serial: got %b expected 1", a_serial); end
    checks++; if ({a_active, a_done, a_wdone} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {a_active, a_done, a_wdone}); end
    checks++; if (bus_a.word_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", bus_a.word_ready_o); end
    checks++; if ({a_state, b_state} !== 6'd0) begin errors++; $display("FAIL reset_state: got %b expected 000000", {a_state, b_state}); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    checks++; if (bus_a.word_ready_o !== 1'b0) begin errors++; $display("FAIL release_ready_early: got %b expected 0", bus_a.word_ready_o); end
    @(posedge clk); #1;
    checks++; if ({bus_a.word_ready_o, bus_b.word_ready_o} !== 2'b11) begin errors++; $display("FAIL release_ready: got %b expected 11", {bus_a.word_ready_o, bus_b.word_ready_o}); end
  endtask

  task automatic test_single_word();
    int waited, nbad, wd_at;
    model_clear();
    div_a = 16'd4;
    model_word(32'h0000_00A5, 4, 4);
    model_idle(3);
    send(1'b0, 32'h0000_00A5, waited);
    capture(exp_q.size(), 1'b0);
    nbad = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        if (nbad < 4) $display("FAIL single_word cycle %0d: got %b expected %b", i, obs_q[i], exp_q[i]);
        nbad++;
      end
    end
    wd_at = -1;
    for (int i = 0; i < obs_q.size(); i++) if (wd_at < 0 && obs_q[i][0] === 1'b1) wd_at = i;
    checks++;
    if (wd_at !== 4 * FL * 4) begin
      errors++;
      $display("FAIL word_done_offset: got %0d expected %0d", wd_at, 4 * FL * 4);
    end
  endtask

  task automatic test_random_words();
    int waited, nbad, d;
    logic [31:0] w;
    for (int n = 0; n < 6; n++) begin
      model_clear();
      w = $urandom;
      d = $urandom_range(0, 5);
      div_a = 16'(d);
      model_word(w, d, 4);
      model_idle(2);
      send(1'b0, w, waited);
      capture(exp_q.size(), 1'b0);
      nbad = 0;
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          if (nbad < 4) $display("FAIL random_word w=%h div=%0d cycle %0d: got %b expected %b", w, d, i, obs_q[i], exp_q[i]);
          nbad++;
        end
      end
    end
  endtask

  task automatic test_div_zero_one();
    int waited, nbad;
    logic [7:0] got;
    logic [7:0] want [4];
    want = '{8'h78, 8'h56, 8'h34, 8'h12};
    for (int d = 0; d < 2; d++) begin
      model_clear();
      div_a = 16'(d);
      model_word(32'h1234_5678, d, 4);
      model_idle(2);
      send(1'b0, 32'h1234_5678, waited);
      capture(exp_q.size(), 1'b0);
      nbad = 0;
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          if (nbad < 4) $display("FAIL div_small div=%0d cycle %0d: got %b expected %b", d, i, obs_q[i], exp_q[i]);
          nbad++;
        end
      end
      for (int k = 0; k < 4; k++) begin
        for (int b = 0; b < 8; b++) got[b] = obs_q[k * FL + 1 + b][3];
        checks++;
        if (got !== want[k]) begin
          errors++;
          $display("FAIL div_small_byte div=%0d byte %0d: got %h expected %h", d, k, got, want[k]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int w1_wait, w2_wait, nbad;
    logic [31:0] w1, w2;
    logic rdy_full;
    model_clear();
    w1 = $urandom;
    w2 = $urandom;
    div_a = 16'd2;
    model_word(w1, 2, 4);
    model_word(w2, 2, 4);
    model_idle(2);
    send(1'b0, w1, w1_wait);
    fork
      capture(exp_q.size(), 1'b0);
      begin
        send(1'b0, w2, w2_wait);
        rdy_full = bus_a.word_ready_o;
        checks++;
        if (rdy_full !== 1'b0) begin errors++; $display("FAIL b2b_ready_full: got %b expected 0", rdy_full); end
        checks++;
        if (w2_wait + 1 >= FL * 2) begin errors++; $display("FAIL b2b_accept_time: accepted %0d cycles in, required < %0d", w2_wait + 1, FL * 2); end
      end
    join
    nbad = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        if (nbad < 4) $display("FAIL back_to_back cycle %0d: got %b expected %b", i, obs_q[i], exp_q[i]);
        nbad++;
      end
    end
    checks++;
    if (bus_a.word_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready_after: got %b expected 1", bus_a.word_ready_o); end
  endtask

  task automatic test_divisor_change();
    int waited, nbad;
    logic [31:0] w;
    model_clear();
    w = $urandom;
    div_a = 16'd3;
    model_byte(w[7:0], 3, 1'b0);
    model_byte(w[15:8], 5, 1'b0);
    model_byte(w[23:16], 5, 1'b0);
    model_byte(w[31:24], 5, 1'b1);
    model_idle(2);
    send(1'b0, w, waited);
    fork
      capture(exp_q.size(), 1'b0);
      begin
        repeat (10) @(posedge clk);
        #1 div_a = 16'd5;
      end
    join
    nbad = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        if (nbad < 4) $display("FAIL divisor_change cycle %0d: got %b expected %b", i, obs_q[i], exp_q[i]);
        nbad++;
      end
    end
  endtask

  task automatic test_num_bytes_one();
    int waited, nbad, d;
    model_clear();
    d = $urandom_range(1, 3);
    div_b = 16'(d);
    model_word(32'hFFFF_FF3C, d, 1);
    model_idle(2);
    send(1'b1, 32'hFFFF_FF3C, waited);
    capture(exp_q.size(), 1'b1);
    nbad = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        if (nbad < 4) $display("FAIL num_bytes_one cycle %0d: got %b expected %b", i, obs_q[i], exp_q[i]);
        nbad++;
      end
    end
    checks++;
    if (obs_q[FL * d] !== 4'b1011) begin
      errors++;
      $display("FAIL num_bytes_one_done: got %b expected 1011", obs_q[FL * d]);
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    int waited, nbad;
    model_clear();
    div_a = 16'd1;
    model_word(32'h0000_07A5, 1, 4);
    model_idle(2);
    send(1'b0, 32'h0000_07A5, waited);
    capture(exp_q.size(), 1'b0);
    nbad = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        if (nbad < 4) $display("FAIL parity cycle %0d: got %b expected %b", i, obs_q[i], exp_q[i]);
        nbad++;
      end
    end
    checks++; if (obs_q[9][3] !== 1'b0) begin errors++; $display("FAIL parity_a5: got %b expected 0", obs_q[9][3]); end
    checks++; if (obs_q[20][3] !== 1'b1) begin errors++; $display("FAIL parity_07: got %b expected 1", obs_q[20][3]); end
    checks++; if (obs_q[11][3] !== 1'b0) begin errors++; $display("FAIL parity_frame_len: got %b expected 0", obs_q[11][3]); end
  endtask
`endif

  task automatic test_reset_mid_byte();
    int waited, nbad;
    logic [31:0] w;
    model_clear();
    w = $urandom & 32'hFFFF_F7FF;   // byte 1, bit 3 forced to 0
    div_a = 16'd4;
    send(1'b0, w, waited);
    repeat (4 * FL + 4 * 4 + 1) @(posedge clk);
    #1;
    checks++; if (a_serial !== 1'b0) begin errors++; $display("FAIL mid_byte_precondition: got %b expected 0", a_serial); end
    rst_n = 1'b0;
    #1;
    checks++; if (a_serial !== 1'b1) begin errors++; $display("FAIL mid_reset_serial: got %b expected 1", a_serial); end
    checks++; if ({a_active, a_done, a_wdone, bus_a.word_ready_o} !== 4'b0000) begin errors++; $display("FAIL mid_reset_flags: got %b expected 0000", {a_active, a_done, a_wdone, bus_a.word_ready_o}); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus_a.word_ready_o !== 1'b1) begin errors++; $display("FAIL mid_release_ready: got %b expected 1", bus_a.word_ready_o); end
    model_idle(60);
    capture(exp_q.size(), 1'b0);
    nbad = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        if (nbad < 4) $display("FAIL after_reset_idle cycle %0d: got %b expected %b", i, obs_q[i], exp_q[i]);
        nbad++;
      end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    bus_a.word_valid_i = 1'b0;
    bus_a.word_i       = '0;
    bus_b.word_valid_i = 1'b0;
    bus_b.word_i       = '0;
    test_reset();
    test_single_word();
    test_random_words();
    test_div_zero_one();
    test_back_to_back();
    test_divisor_change();
    test_num_bytes_one();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_reset_mid_byte();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_word_tx.md
UART_WORD_TX -- requirements
Module: uart_word_tx

Interface
REQ-001 Parameter NUM_BYTES, default 4, SHALL set the bytes sent per accepted word; legal values 1..4.
REQ-002 clk_i  input  1  sole clock, rising edge.
REQ-003 rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 clks_per_bit_i  input  16  baud divisor in clk_i cycles per bit, same meaning as the receiver's CLKS_PER_BIT; 10417 in SoC use.
REQ-005 word_valid_i  input  1  word offered.
REQ-006 word_i  input  32  word payload.
REQ-007 word_ready_o  output  1  holding buffer empty; a word is accepted on word_valid_i && word_ready_o.
REQ-008 o_Tx_Serial  output  1  serial line, idle high.
REQ-009 o_Tx_Active  output  1  high from the first start-bit cycle to the last stop-bit cycle of any byte.
REQ-010 o_Tx_Done  output  1  one-cycle pulse after each byte's stop bit completes.
REQ-011 o_Word_Done  output  1  one-cycle pulse, coincident with o_Tx_Done of the last byte of a word.

Function
REQ-012 Framing SHALL be 8N1: start bit 0, 8 data bits LSB first, stop bit 1.
REQ-013 Bytes of a word SHALL be sent least-significant byte first: word_i[7:0], then [15:8], up to NUM_BYTES bytes; upper bytes are ignored.
REQ-014 Each bit SHALL last exactly max(clks_per_bit_i,1) cycles; the divisor SHALL be sampled at each byte's start-bit entry and held for that byte.
REQ-015 The FSM SHALL have states IDLE, START, DATA, STOP, with optional PARITY (see REQ-026).
REQ-016 IDLE->START in the cycle after a word reaches the shift register; START->DATA, DATA->DATA (bit index 0..7), DATA->STOP after bit 7, STOP->START if bytes remain or the holding buffer is full, else STOP->IDLE.
REQ-017 Storage: one shift word plus one holding word; word_ready_o SHALL be high whenever the holding word is empty, including during transmission.
REQ-018 Latency: word accepted in cycle N while IDLE with empty shift word -> o_Tx_Serial low from cycle N+1.
REQ-019 Back-to-back: a held word SHALL move to the shift word at the end of the previous word's last stop bit, with zero idle cycles between stop and next start.
REQ-020 Accept and shift-word release in the same cycle SHALL both take effect; no word lost or duplicated.
REQ-021 word_i SHALL be captured on acceptance; later changes to word_i SHALL not affect transmission.
REQ-022 Bit counter SHALL count 0..divisor-1 and wrap; no 16-bit overflow for divisor 65535.

Reset
REQ-023 On rst_ni low, asynchronously: FSM=IDLE, buffers empty, counters 0, o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, o_Word_Done=0, word_ready_o=0.
REQ-024 word_ready_o SHALL rise in the first clock after reset release.
REQ-025 Reset mid-byte SHALL abort the frame immediately, with the line high; no resumption after release.

Configuration
REQ-026 Macro UART_TX_PARITY_EN: when defined, a PARITY state with one even-parity bit (XOR of the 8 data bits) SHALL be inserted between DATA and STOP, for 11-bit frames; when undefined, PARITY logic is absent and frames are 10 bits.

Verification
REQ-027 divisor=4, word 0x000000A5, NUM_BYTES=4 -> line 0,1,0,1,0,0,1,0,1,1 per byte in 4-cycle bits; bytes A5,00,00,00; o_Word_Done 160 cycles after the first start cycle.
REQ-028 Two words offered back-to-back, divisor=2 -> second accepted during the first word's byte 0; zero idle gap at the word boundary; 4 o_Tx_Done pulses per word.
REQ-029 divisor=0 and divisor=1 -> every bit lasts 1 cycle; word 0x12345678 sent as 78,56,34,12.
REQ-030 rst_ni low during bit 3 of byte 1 -> o_Tx_Serial=1 the same cycle; after release, line idle and word_ready_o=1 one cycle later; no Done pulses.
REQ-031 UART_TX_PARITY_EN defined, byte 0xA5 -> parity bit 0; byte 0x07 -> parity bit 1; frame length 11 bits.
REQ-032 NUM_BYTES=1, word 0xFFFFFF3C -> only byte 3C sent; o_Tx_Done and o_Word_Done pulse together.
